mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_wait_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/MEM shared-SRAM arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_e;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Loadable 4-bit down-counter that saturates at zero; zero flag is combinational.
module wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one wait-stated SRAM.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              freeze_if,
    output logic              freeze_pipe
);

    state_e            state_q,      state_d;
    owner_e            owner_q,      owner_d;
    logic              sram_en_q,    sram_en_d;
    logic              sram_we_q,    sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q,  mem_rdata_d;
    logic              if_ready_q,   if_ready_d;
    logic              mem_ready_q,  mem_ready_d;

    logic mem_req_c;
    logic cnt_load_c;
    logic cnt_dec_c;
    logic cnt_zero_c;

    assign mem_req_c = mem_rd_en | mem_wr_en;

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec_c),
        .zero_c   (cnt_zero_c)
    );

    // Next-state and registered-output logic; the SRAM bus is frozen from grant to last access cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        sram_en_d    = sram_en_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        cnt_load_c   = 1'b0;
        cnt_dec_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_c) begin
                    owner_d      = OWN_MEM;
                    sram_en_d    = 1'b1;
                    sram_we_d    = mem_wr_en;
                    sram_addr_d  = mem_addr;
                    sram_wdata_d = mem_wdata;
                    cnt_load_c   = 1'b1;
                    state_d      = ACCESS;
                end else if (if_req) begin
                    owner_d     = OWN_IF;
                    sram_en_d   = 1'b1;
                    sram_we_d   = 1'b0;
                    sram_addr_d = if_addr;
                    cnt_load_c  = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero_c) begin
                    if (!sram_we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = sram_rdata;
                        end else begin
                            mem_rdata_d = sram_rdata;
                        end
                    end
                    if_ready_d  = (owner_q == OWN_IF);
                    mem_ready_d = (owner_q == OWN_MEM);
                    sram_en_d   = 1'b0;
                    sram_we_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
        end
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;

    // Pipeline stalls follow the live request and drop in the ready cycle.
    assign freeze_if   = if_req & ~if_ready_q;
    assign freeze_pipe = mem_req_c & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has WAIT_CYCLES=2, instance 1 has WAIT_CYCLES=0.
module tb_mem_arbiter;

    logic        clk;
    logic        rst         [2];
    logic        if_req      [2];
    logic [31:0] if_addr     [2];
    logic [31:0] if_rdata    [2];
    logic        if_ready    [2];
    logic        mem_rd_en   [2];
    logic        mem_wr_en   [2];
    logic [31:0] mem_addr    [2];
    logic [31:0] mem_wdata   [2];
    logic [31:0] mem_rdata   [2];
    logic        mem_ready   [2];
    logic        sram_en     [2];
    logic        sram_we     [2];
    logic [31:0] sram_addr   [2];
    logic [31:0] sram_wdata  [2];
    logic [31:0] sram_rdata  [2];
    logic        freeze_if   [2];
    logic        freeze_pipe [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] last_if_rd  [2];
    logic [31:0] last_mem_rd [2];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_wr_en(mem_wr_en[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
        .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
        .freeze_if(freeze_if[0]), .freeze_pipe(freeze_pipe[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_wr_en(mem_wr_en[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
        .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
        .freeze_if(freeze_if[1]), .freeze_pipe(freeze_pipe[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] sram_peek(input logic [31:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_peek(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // SRAM behaviour: writes land on the clock edge, read data is presented mid-cycle.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (sram_en[s] && sram_we[s]) sram_mem[sram_addr[s]] = sram_wdata[s];
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) sram_rdata[s] = sram_peek(sram_addr[s]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int s, input string tag);
        check({tag, "_sram_en"},     64'(sram_en[s]),     64'(0));
        check({tag, "_sram_we"},     64'(sram_we[s]),     64'(0));
        check({tag, "_sram_addr"},   64'(sram_addr[s]),   64'(0));
        check({tag, "_sram_wdata"},  64'(sram_wdata[s]),  64'(0));
        check({tag, "_if_ready"},    64'(if_ready[s]),    64'(0));
        check({tag, "_mem_ready"},   64'(mem_ready[s]),   64'(0));
        check({tag, "_if_rdata"},    64'(if_rdata[s]),    64'(0));
        check({tag, "_mem_rdata"},   64'(mem_rdata[s]),   64'(0));
        check({tag, "_freeze_if"},   64'(freeze_if[s]),   64'(0));
        check({tag, "_freeze_pipe"}, 64'(freeze_pipe[s]), 64'(0));
    endtask

    // One isolated access; kind 0=IF read, 1=load, 2=store, 3=rd+wr (store).
    task automatic txn(input int s, input int kind, input logic [31:0] addr, input logic [31:0] wdata);
        int  lat;
        int  got_rdy;
        int  en_cnt;
        int  pulses;
        bit  is_if;
        bit  wr;
        logic rdy;
        lat     = wc(s) + 2;
        got_rdy = -1;
        en_cnt  = 0;
        pulses  = 0;
        is_if   = (kind == 0);
        wr      = (kind >= 2);
        if (is_if) last_if_rd[s] = ref_peek(addr);
        else if (wr) ref_mem[addr] = wdata;
        else last_mem_rd[s] = ref_peek(addr);

        if (is_if) begin
            if_req[s]  = 1'b1;
            if_addr[s] = addr;
        end else begin
            mem_rd_en[s] = (kind == 1) || (kind == 3);
            mem_wr_en[s] = wr;
            mem_addr[s]  = addr;
            mem_wdata[s] = wdata;
        end
        #1;
        check("freeze_if_c0",   64'(freeze_if[s]),   64'(is_if));
        check("freeze_pipe_c0", 64'(freeze_pipe[s]), 64'(!is_if));
        for (int c = 1; c <= lat + 2; c++) begin
            @(posedge clk); #1;
            if (sram_en[s]) begin
                en_cnt++;
                check("sram_we",   64'(sram_we[s]),   64'(wr));
                check("sram_addr", 64'(sram_addr[s]), 64'(addr));
                if (wr) check("sram_wdata", 64'(sram_wdata[s]), 64'(wdata));
            end
            rdy = is_if ? if_ready[s] : mem_ready[s];
            check("other_ready", 64'(is_if ? mem_ready[s] : if_ready[s]), 64'(0));
            if (c <= lat) begin
                check("freeze", 64'(is_if ? freeze_if[s] : freeze_pipe[s]), 64'(c != lat));
            end
            if (rdy) begin
                pulses++;
                if (got_rdy < 0) got_rdy = c;
            end
            if (c == lat) begin
                check("if_rdata",  64'(if_rdata[s]),  64'(last_if_rd[s]));
                check("mem_rdata", 64'(mem_rdata[s]), 64'(last_mem_rd[s]));
                if_req[s]    = 1'b0;
                mem_rd_en[s] = 1'b0;
                mem_wr_en[s] = 1'b0;
            end else if (c == 1) begin
                if_addr[s]   = $urandom;
                mem_addr[s]  = $urandom;
                mem_wdata[s] = $urandom;
            end
        end
        check("latency",     64'(got_rdy), 64'(lat));
        check("sram_en_len", 64'(en_cnt),  64'(wc(s) + 1));
        check("ready_pulse", 64'(pulses),  64'(1));
    endtask

    // IF and MEM raised together; MEM must go first. drop_if withdraws IF before its grant.
    task automatic dual(input int s, input bit mwr, input logic [31:0] ia, input logic [31:0] ma,
                        input logic [31:0] wd, input bit drop_if);
        int w;
        int mlat;
        int ilat;
        int last;
        int en_cnt;
        int mr;
        int ir;
        w      = wc(s);
        mlat   = w + 2;
        ilat   = (w + 3) + (w + 2);
        en_cnt = 0;
        mr     = -1;
        ir     = -1;
        if (mwr) ref_mem[ma] = wd;
        else last_mem_rd[s] = ref_peek(ma);
        if (!drop_if) last_if_rd[s] = ref_peek(ia);
        last = drop_if ? mlat + 3 : ilat + 2;

        if_req[s]    = 1'b1;
        if_addr[s]   = ia;
        mem_rd_en[s] = !mwr;
        mem_wr_en[s] = mwr;
        mem_addr[s]  = ma;
        mem_wdata[s] = wd;
        #1;
        check("dual_freeze_if_c0",   64'(freeze_if[s]),   64'(1));
        check("dual_freeze_pipe_c0", 64'(freeze_pipe[s]), 64'(1));
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (sram_en[s]) en_cnt++;
            if (mem_ready[s] && mr < 0) mr = c;
            if (if_ready[s] && ir < 0) ir = c;
            if (if_req[s]) check("dual_freeze_if", 64'(freeze_if[s]), 64'(c != ilat));
            if (c == 1 && drop_if) if_req[s] = 1'b0;
            if (c == mlat) begin
                check("dual_mem_rdata", 64'(mem_rdata[s]), 64'(last_mem_rd[s]));
                mem_rd_en[s] = 1'b0;
                mem_wr_en[s] = 1'b0;
            end
            if (c == ilat && !drop_if) begin
                check("dual_if_rdata", 64'(if_rdata[s]), 64'(last_if_rd[s]));
                if_req[s] = 1'b0;
            end
        end
        if_req[s] = 1'b0;
        check("dual_mem_lat", 64'(mr), 64'(mlat));
        check("dual_if_lat",  64'(ir), 64'(drop_if ? -1 : ilat));
        check("dual_en_cnt",  64'(en_cnt), 64'(drop_if ? w + 1 : 2 * (w + 1)));
    endtask

    // Continuous IF fetching: a new address is presented in each ready cycle.
    task automatic b2b(input int s, input int n);
        int w;
        int k;
        int en_cnt;
        logic [31:0] cur;
        w      = wc(s);
        k      = 0;
        en_cnt = 0;
        cur    = 32'(($urandom_range(0, 15)) << 2);
        last_if_rd[s] = ref_peek(cur);
        if_req[s]  = 1'b1;
        if_addr[s] = cur;
        for (int c = 1; c <= n * (w + 3) + 2; c++) begin
            @(posedge clk); #1;
            if (sram_en[s]) begin
                en_cnt++;
                check("b2b_sram_addr", 64'(sram_addr[s]), 64'(cur));
            end
            if (if_ready[s]) begin
                check("b2b_ready_cyc", 64'(c), 64'((w + 2) + k * (w + 3)));
                check("b2b_if_rdata",  64'(if_rdata[s]), 64'(last_if_rd[s]));
                k++;
                if (k < n) begin
                    cur = 32'(($urandom_range(0, 15)) << 2);
                    last_if_rd[s] = ref_peek(cur);
                    if_addr[s] = cur;
                end else begin
                    if_req[s] = 1'b0;
                end
            end
        end
        if_req[s] = 1'b0;
        check("b2b_count",  64'(k),      64'(n));
        check("b2b_en_cnt", 64'(en_cnt), 64'(n * (w + 1)));
    endtask

    // Reset lands in the 2nd ACCESS cycle of an IF read.
    task automatic reset_mid(input int s);
        if_req[s]  = 1'b1;
        if_addr[s] = 32'h0000_0008;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_en", 64'(sram_en[s]), 64'(1));
        rst[s]    = 1'b1;
        if_req[s] = 1'b0;
        @(posedge clk); #1;
        chk_zero(s, "rst_mid");
        rst[s] = 1'b0;
        last_if_rd[s]  = '0;
        last_mem_rd[s] = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_quiet_en", 64'(sram_en[s]) | 64'(if_ready[s]) | 64'(mem_ready[s]), 64'(0));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s]         = 1'b1;
            if_req[s]      = 1'b0;
            if_addr[s]     = '0;
            mem_rd_en[s]   = 1'b0;
            mem_wr_en[s]   = 1'b0;
            mem_addr[s]    = '0;
            mem_wdata[s]   = '0;
            last_if_rd[s]  = '0;
            last_mem_rd[s] = '0;
        end
        sram_mem[32'h10] = 32'hDEAD_BEEF;
        ref_mem[32'h10]  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "reset_w2");
        chk_zero(1, "reset_w0");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk); #1;

        txn(0, 0, 32'h10, 32'h0);
        check("fetch_deadbeef", 64'(if_rdata[0]), 64'(32'hDEAD_BEEF));

        txn(0, 1, 32'h10, 32'h0);
        txn(0, 2, 32'h20, 32'h1234_5678);
        check("store_keeps_mem_rdata", 64'(mem_rdata[0]), 64'(32'hDEAD_BEEF));
        txn(0, 3, 32'h24, 32'hCAFE_F00D);
        txn(0, 0, 32'h20, 32'h0);

        dual(0, 1'b0, 32'h04, 32'h80, 32'h0, 1'b0);
        dual(0, 1'b1, 32'h20, 32'h20, 32'hA5A5_1234, 1'b0);
        dual(0, 1'b0, 32'h28, 32'h24, 32'h0, 1'b1);
        dual(1, 1'b0, 32'h0C, 32'h24, 32'h0, 1'b0);

        b2b(1, 4);
        b2b(0, 3);

        reset_mid(0);
        txn(0, 0, 32'h10, 32'h0);
        txn(0, 1, 32'h20, 32'h0);

        for (int i = 0; i < 80; i++) begin
            int s;
            logic [31:0] a;
            logic [31:0] a2;
            s  = int'($urandom_range(0, 1));
            a  = 32'(($urandom_range(0, 15)) << 2);
            a2 = 32'(($urandom_range(0, 15)) << 2);
            if (i % 6 == 5) dual(s, 1'($urandom_range(0, 1)), a, a2, $urandom, 1'($urandom_range(0, 1)));
            else txn(s, int'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
